demux_sequencial: RTL and testbench



---
 rtl/demux_sequencial.sv | 78 +++++++
 tb/tb_demux_sequencial.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/demux_sequencial.sv
// Serial-to-parallel demultiplexer: reassembles N serial slots from a select-counter
// driven mux back into an N-bit word, publishing it with a one-cycle valid pulse.
module demux_sequencial #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Y,
  input  logic          en,
  input  logic          start,
  output logic [SW-1:0] S,
  output logic [N-1:0]  D,
  output logic          valid,
  output logic          busy,
  output logic          err
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  state_t       state;
  logic [N-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      S      <= '0;
      D      <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          // Stray bits without start are silently dropped.
          if (en && start) begin
            shadow <= {{(N-1){1'b0}}, Y};
            S      <= ONE;
            busy   <= 1'b1;
            state  <= RECV;
          end
        end
        RECV: begin
          if (en) begin
            if (start) begin
              // Resync: the current bit opens a fresh frame, old partial is lost.
              err    <= 1'b1;
              shadow <= {{(N-1){1'b0}}, Y};
              S      <= ONE;
            end else if (S == LAST) begin
              D      <= {Y, shadow[N-2:0]};
              valid  <= 1'b1;
              shadow <= '0;
              S      <= '0;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              shadow[S] <= Y;
              S         <= S + ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          S     <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sequencial.sv
// Scoreboard bench for demux_sequencial: directed frames push expected words/errors,
// a negedge monitor pops and compares whenever valid or err is presented.
module tb_demux_sequencial;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst, Y, en, start;
  logic [SW-1:0] S;
  logic [N-1:0]  D;
  logic          valid, busy, err;

  demux_sequencial #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst(rst), .Y(Y), .en(en), .start(start),
    .S(S), .D(D), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [N-1:0] exp_d_q[$];
  int           exp_err_q[$];
  int           vcyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented valid/err must match a pending expectation.
  always @(negedge clk) begin
    if (valid) begin
      vcyc_q.push_back(cyc);
      if (exp_d_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("D_word", D, exp_d_q.pop_front());
    end
    if (err) begin
      if (exp_err_q.size() == 0) chk("unexpected_err", 1, 0);
      else chk("err_pulse", 1, exp_err_q.pop_front());
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic send(input logic st, input logic y, input int exp_s, input int exp_busy);
    en = 1'b1; start = st; Y = y;
    @(posedge clk); #1;
    en = 1'b0; start = 1'b0; Y = 1'b0;
    chk("S_after_bit", S, exp_s);
    chk("busy_after_bit", busy, exp_busy);
  endtask

  task automatic idle(input int n, input int exp_s, input int exp_busy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("S_hold", S, exp_s);
      chk("busy_hold", busy, exp_busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_S", S, 0);
    chk("rst_D", D, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    rst = 1'b0; Y = 1'b0; en = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic frame 1,1,0,0 -> 4'b0011
    send(1, 1, 1, 1);
    send(0, 1, 2, 1);
    send(0, 0, 3, 1);
    exp_d_q.push_back(4'b0011);
    send(0, 0, 0, 0);
    idle(2, 0, 0);

    // Gapped frame 0,1,0,1 -> 4'b1010
    send(1, 0, 1, 1); idle(2, 1, 1);
    send(0, 1, 2, 1); idle(2, 2, 1);
    send(0, 0, 3, 1); idle(2, 3, 1);
    exp_d_q.push_back(4'b1010);
    send(0, 1, 0, 0);
    idle(2, 0, 0);

    // Start mid-frame: partial 1,1 discarded, new frame 0,1,1,1 -> 4'b1110
    send(1, 1, 1, 1);
    send(0, 1, 2, 1);
    exp_err_q.push_back(1);
    send(1, 0, 1, 1);
    send(0, 1, 2, 1);
    send(0, 1, 3, 1);
    exp_d_q.push_back(4'b1110);
    send(0, 1, 0, 0);
    idle(2, 0, 0);
    chk("D_after_resync", D, 4'b1110);

    // Reset mid-frame, then 1,0,0,1 -> 4'b1001
    send(1, 1, 1, 1);
    send(0, 0, 2, 1);
    do_reset();
    send(1, 1, 1, 1);
    send(0, 0, 2, 1);
    send(0, 0, 3, 1);
    exp_d_q.push_back(4'b1001);
    send(0, 1, 0, 0);
    idle(1, 0, 0);

    // Back-to-back frames 1,1,1,1 then 0,1,1,0
    vcyc_q.delete();
    send(1, 1, 1, 1);
    send(0, 1, 2, 1);
    send(0, 1, 3, 1);
    exp_d_q.push_back(4'b1111);
    send(0, 1, 0, 0);
    send(1, 0, 1, 1);
    send(0, 1, 2, 1);
    send(0, 1, 3, 1);
    exp_d_q.push_back(4'b0110);
    send(0, 0, 0, 0);
    idle(2, 0, 0);
    chk("b2b_valid_count", vcyc_q.size(), 2);
    if (vcyc_q.size() == 2) chk("b2b_valid_spacing", vcyc_q[1] - vcyc_q[0], 4);

    // Stray data in IDLE is ignored
    send(0, 1, 0, 0);
    send(0, 1, 0, 0);
    send(0, 1, 0, 0);
    idle(2, 0, 0);
    chk("stray_D_unchanged", D, 4'b0110);

    chk("pending_words", exp_d_q.size(), 0);
    chk("pending_errs", exp_err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
